dcache_store_port_arbiter: RTL

- Shares the single D$ store/write request port between NR_PORTS store-side requesters, e.g. store buffer commit path and AMO/cache-maintenance path.
- Arbitration is round-robin. A granted-pending request is locked until the cache accepts it.
- Tracks in-order outstanding write responses and routes each one back to its originator.
- Provides a drain handshake so the controller can quiesce the port before fence or flush.

---
 rtl/dcache_store_port_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/dcache_store_port_arbiter.sv
// Round-robin arbiter sharing the single D$ store port between NR_PORTS requesters,
// with a grant lock, an in-order response-routing FIFO and a drain handshake.
module dcache_store_port_arbiter #(
    parameter int NR_PORTS        = 2,
    parameter int ADDR_WIDTH      = 56,
    parameter int DATA_WIDTH      = 64,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NR_PORTS-1:0]                 req_valid_i,
    output logic [NR_PORTS-1:0]                 req_ready_o,
    input  logic [NR_PORTS*ADDR_WIDTH-1:0]      req_addr_i,
    input  logic [NR_PORTS*DATA_WIDTH-1:0]      req_data_i,
    input  logic [NR_PORTS*DATA_WIDTH/8-1:0]    req_be_i,
    input  logic [NR_PORTS*2-1:0]               req_size_i,
    output logic [NR_PORTS-1:0]                 rsp_valid_o,
    output logic                                mem_req_o,
    input  logic                                mem_gnt_i,
    output logic [ADDR_WIDTH-1:0]               mem_addr_o,
    output logic [DATA_WIDTH-1:0]               mem_data_o,
    output logic [DATA_WIDTH/8-1:0]             mem_be_o,
    output logic [1:0]                          mem_size_o,
    input  logic                                mem_rvalid_i,
    input  logic                                drain_i,
    output logic                                drained_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
    output logic                                err_o
);

    localparam int IDX_W = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int BE_W  = DATA_WIDTH / 8;

    typedef enum logic {
        IDLE,
        LOCKED
    } arb_state_e;

    arb_state_e         r_state;
    logic [IDX_W-1:0]   r_rrPtr;
    logic [IDX_W-1:0]   r_lockIdx;
    logic [IDX_W-1:0]   r_fifo [MAX_OUTSTANDING];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;
    logic               r_err;

    logic [ADDR_WIDTH-1:0] w_addrArr [NR_PORTS];
    logic [DATA_WIDTH-1:0] w_dataArr [NR_PORTS];
    logic [BE_W-1:0]       w_beArr   [NR_PORTS];
    logic [1:0]            w_sizeArr [NR_PORTS];

    logic [IDX_W-1:0]   w_cand;
    logic [IDX_W-1:0]   w_winner;
    logic               w_found;
    logic               w_countFull;
    logic               w_arbStart;
    logic               w_locked;
    logic [IDX_W-1:0]   w_sel;
    logic [IDX_W-1:0]   w_nextPtr;
    logic               w_grant;
    logic               w_pop;
    logic               w_rvalidErr;

    for (genvar k = 0; k < NR_PORTS; k++) begin : g_unpack
        assign w_addrArr[k] = req_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_dataArr[k] = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
        assign w_beArr[k]   = req_be_i[k*BE_W +: BE_W];
        assign w_sizeArr[k] = req_size_i[k*2 +: 2];
    end

    // Scan ports starting at the round-robin pointer; first valid one wins.
    always_comb begin
        w_cand   = '0;
        w_winner = '0;
        w_found  = 1'b0;
        for (int i = 0; i < NR_PORTS; i++) begin
            w_cand = IDX_W'((int'(r_rrPtr) + i) % NR_PORTS);
            if (!w_found && req_valid_i[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    assign w_countFull = (r_count == CNT_W'(MAX_OUTSTANDING));
    assign w_arbStart  = !rst_i && (r_state == IDLE) && w_found && !drain_i && !w_countFull;
    assign w_locked    = !rst_i && (r_state == LOCKED);
    assign w_sel       = (r_state == LOCKED) ? r_lockIdx : w_winner;
    assign w_nextPtr   = (w_sel == IDX_W'(NR_PORTS - 1)) ? '0 : w_sel + 1'b1;
    assign w_grant     = mem_req_o && mem_gnt_i;
    assign w_pop       = !rst_i && mem_rvalid_i && (r_count != '0);
    assign w_rvalidErr = mem_rvalid_i && (r_count == '0);

    assign mem_req_o   = w_arbStart || w_locked;
    assign req_ready_o = w_grant ? (NR_PORTS'(1) << w_sel) : '0;
    assign rsp_valid_o = w_pop ? (NR_PORTS'(1) << r_fifo[r_head]) : '0;

    assign drained_o     = drain_i && !rst_i && (r_state == IDLE) && (r_count == '0);
    assign outstanding_o = r_count;
    assign err_o         = r_err;

    // Payload is forced to zero whenever no request is presented.
    always_comb begin
        mem_addr_o = '0;
        mem_data_o = '0;
        mem_be_o   = '0;
        mem_size_o = '0;
        if (mem_req_o) begin
            mem_addr_o = w_addrArr[w_sel];
            mem_data_o = w_dataArr[w_sel];
            mem_be_o   = w_beArr[w_sel];
            mem_size_o = w_sizeArr[w_sel];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_rrPtr   <= '0;
            r_lockIdx <= '0;
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_err     <= 1'b0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                r_fifo[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_arbStart && !mem_gnt_i) begin
                        r_lockIdx <= w_winner;
                        r_state   <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (mem_gnt_i) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (w_grant) begin
                r_fifo[r_tail] <= w_sel;
                r_tail         <= r_tail + 1'b1;
                r_rrPtr        <= w_nextPtr;
            end

            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end

            // A grant and a completion in the same cycle cancel out.
            case ({w_grant, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase

            if (w_rvalidErr) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule
